// File: rtl/q2_sequencer_pkg.sv
// Q2 sequencer shared definitions.
// State codes, opcode field positions and run-state encoding.
package q2_sequencer_pkg;

  localparam int Q2_ALU_CYCLES_DEF = 8;

  localparam logic [3:0] Q2_ST_FETCH = 4'd0;
  localparam logic [3:0] Q2_ST_LOAD  = 4'd1;
  localparam logic [3:0] Q2_ST_DEREF = 4'd2;
  localparam logic [3:0] Q2_ST_EXEC  = 4'd3;
  localparam logic [3:0] Q2_ST_ALU0  = 4'd4;

  // dbus_op carries data-bus bits 5..2
  localparam int Q2_OP5 = 3;
  localparam int Q2_OP4 = 2;
  localparam int Q2_OP3 = 1;
  localparam int Q2_OP2 = 0;

  typedef enum logic {
    RUN_IDLE,
    RUN_ACTIVE
  } run_st_e;

  function automatic logic [3:0] q2_alu_last(input int n);
    return 4'(3 + n);
  endfunction

endpackage

// File: rtl/q2_sequencer_if.sv
// Q2 sequencer front-panel / decoder bundle.
// master = sequencer side, slave = panel + decoder side.
interface q2_sequencer_if;

  logic       run_sw;
  logic       step_sw;
  logic [3:0] dbus_op;
  logic       s0;
  logic       s1;
  logic       s2;
  logic       s3;
  logic       ws;
  logic       running;

  modport master (
    input  run_sw,
    input  step_sw,
    input  dbus_op,
    output s0,
    output s1,
    output s2,
    output s3,
    output ws,
    output running
  );

  modport slave (
    output run_sw,
    output step_sw,
    output dbus_op,
    input  s0,
    input  s1,
    input  s2,
    input  s3,
    input  ws,
    input  running
  );

endinterface

// File: rtl/q2_edge_detect.sv
// Registered rising-edge detector for front-panel switches.
// Reset loads the current level so a held switch never fires.
module q2_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= sig_i;
    end else begin
      hist_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~hist_q;

endmodule

// File: rtl/q2_sequencer.sv
// Q2 machine-cycle sequencer: state code, write strobe,
// run/stop and single-step control.
module q2_sequencer
  import q2_sequencer_pkg::*;
#(
  parameter int ALU_CYCLES = Q2_ALU_CYCLES_DEF
) (
  input logic             clk,
  input logic             rst_n,
  q2_sequencer_if.master  bus
);

  localparam logic [3:0] ALU_LAST = q2_alu_last(ALU_CYCLES);

  run_st_e    run_st_q;
  run_st_e    run_st_d;
  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       phase_q;
  logic       phase_d;
  logic [3:0] op_q;
  logic [3:0] op_d;
  logic       one_q;
  logic       one_d;
  logic       step_rise;
  logic       eoi;

  q2_edge_detect u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (bus.step_sw),
    .rise_o (step_rise)
  );

  always_comb begin
    run_st_d = run_st_q;
    state_d  = state_q;
    phase_d  = phase_q;
    op_d     = op_q;
    one_d    = one_q;
    eoi      = 1'b0;

    unique case (run_st_q)
      RUN_IDLE: begin
        state_d = Q2_ST_FETCH;
        phase_d = 1'b0;
        if (bus.run_sw) begin
          run_st_d = RUN_ACTIVE;
          one_d    = 1'b0;
        end else if (step_rise) begin
          run_st_d = RUN_ACTIVE;
          one_d    = 1'b1;
        end
      end

      RUN_ACTIVE: begin
        phase_d = ~phase_q;
        // state only advances on the strobe-phase edge
        if (phase_q) begin
          unique case (1'b1)
            (state_q == Q2_ST_FETCH): begin
              op_d    = bus.dbus_op;
              state_d = bus.dbus_op[Q2_OP5]
                      ? Q2_ST_EXEC : Q2_ST_LOAD;
            end
            (state_q == Q2_ST_LOAD): begin
              state_d = op_q[Q2_OP2]
                      ? Q2_ST_DEREF : Q2_ST_ALU0;
            end
            (state_q == Q2_ST_DEREF): begin
              state_d = Q2_ST_ALU0;
            end
            (state_q == Q2_ST_EXEC): begin
              if (!op_q[Q2_OP4] && !op_q[Q2_OP3]) begin
                state_d = Q2_ST_ALU0;
              end else begin
                eoi = 1'b1;
              end
            end
            (state_q >= ALU_LAST): begin
              eoi = 1'b1;
            end
            default: begin
              state_d = 4'(state_q + 4'd1);
            end
          endcase

          if (eoi) begin
            state_d = Q2_ST_FETCH;
            if (!(bus.run_sw && !one_q)) begin
              run_st_d = RUN_IDLE;
              one_d    = 1'b0;
            end
          end
        end
      end

      default: begin
        run_st_d = RUN_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_st_q <= RUN_IDLE;
      state_q  <= Q2_ST_FETCH;
      phase_q  <= 1'b0;
      op_q     <= 4'd0;
      one_q    <= 1'b0;
    end else begin
      run_st_q <= run_st_d;
      state_q  <= state_d;
      phase_q  <= phase_d;
      op_q     <= op_d;
      one_q    <= one_d;
    end
  end

  assign bus.s0      = state_q[0];
  assign bus.s1      = state_q[1];
  assign bus.s2      = state_q[2];
  assign bus.s3      = state_q[3];
  assign bus.ws      = phase_q;
  assign bus.running = (run_st_q == RUN_ACTIVE);

endmodule
